serv_seq_ctrl: RTL
==================

# serv_seq_ctrl

Parametrised successor of the SERV core state controller: sequences the per-instruction phases (IDLE, INIT, RUN, TRAP) for a datapath processing W bits per cycle, so one 32-bit pass takes 32/W cycles. Adds a stall input that freezes sequencing and a 5-bit mcause with an interrupt flag. Sits between decode, register-file interface, ALU/bufreg and CSR unit.

## Interface
- W, 1, bits processed per cycle; legal 1, 2, 4, 8
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_new_irq  in  1  interrupt request pulse (SERV_IRQ_EN only)
- i_rf_ready  in  1  register file ready to start instruction
- i_stall  in  1  freeze counter and state (non-IDLE)
- i_take_branch, i_branch_op, i_mem_op, i_shift_op, i_slt_op, i_mem_cmd, i_e_op, i_ebreak  in  1 each  decode/ALU qualifiers
- i_rs1_addr  in  5  rs1 field (CSR immediate)
- i_ctrl_misalign, i_mem_misalign, i_alu_sh_done  in  1 each  status
- o_init, o_run, o_ctrl_trap  out  1 each  state decodes
- o_cnt_en  out  1  state != IDLE and !i_stall
- o_cnt  out  5  bit index of current chunk, steps by W
- o_cnt_done  out  1  last chunk of pass
- o_ctrl_pc_en, o_ctrl_jump, o_rf_rs_en, o_alu_shamt_en, o_dbus_cyc, o_bufreg_hold  out  1 each
- o_mem_bytecnt  out  2  o_cnt[4:3]
- o_csr_imm  out  W  i_rs1_addr bits o_cnt..o_cnt+W-1, zero for indices >= 5
- o_csr_mcause  out  5  {interrupt, code[3:0]}

## Operation
- two_stage = slt|mem|branch|shift; mem_misalign = i_mem_op & i_mem_misalign.
- IDLE: on i_rf_ready -> TRAP if i_e_op or pending_irq; else INIT if two_stage & !stage_two_pending; else RUN. Without i_rf_ready: i_alu_sh_done & i_shift_op & stage_two_pending -> RUN.
- INIT on o_cnt_done: TRAP if mem_misalign or (i_take_branch & i_ctrl_misalign); else IDLE if mem or shift op; else RUN.
- RUN, TRAP on o_cnt_done -> IDLE; TRAP clears pending_irq.
- stage_two_pending: set when leaving INIT, cleared when leaving RUN/TRAP.
- o_ctrl_jump: loads i_take_branch in INIT, cleared in IDLE.
- o_ctrl_pc_en = RUN|TRAP; o_rf_rs_en = two_stage ? INIT : o_ctrl_pc_en; o_alu_shamt_en = INIT & o_cnt < 5.
- o_dbus_cyc = IDLE & stage_two_pending & i_mem_op & !mem_misalign.
- o_bufreg_hold registered: i_shift_op & o_cnt_done of previous cycle.
- mcause registered every cycle, priority: e_op {0, !ebreak,3'b011} > mem_misalign {0,2'b01,i_mem_cmd,0} > pending_irq {1,4'd7} > 0.

## Timing
- o_cnt advances W per non-stalled cycle, wraps 32-W -> 0; o_cnt_done = o_cnt_en & o_cnt == 32-W (combinational); each phase exactly 32/W active cycles.
- i_stall: no counter, state, jump or stage_two_pending update; stall on done cycle delays transition.
- Reset values: state IDLE, o_cnt 0, mcause 0, jump 0, hold 0, pending_irq 0, stage_two_pending 0. Reset mid-pass aborts immediately.
- i_new_irq in same cycle as TRAP exit: set wins, irq retained.

## Configuration
- SERV_IRQ_EN defined: pending_irq register, i_new_irq honoured, interrupt mcause. Undefined: pending_irq tied 0, i_new_irq ignored, mcause[4] = 0.

## Structure
- Shared package serv_pkg: state encoding (IDLE 0, INIT 1, RUN 2, TRAP 3), mcause code constants, legal-W check.
- Sub-module serv_seq_cnt: o_cnt / o_cnt_done / stall logic.

## Test plan
- W=1 ADD: rf_ready in IDLE -> RUN 32 cycles, o_cnt 0..31, done at 31, back IDLE.
- W=4 load: INIT 8 cycles -> IDLE, o_dbus_cyc=1 next cycle, bytecnt follows o_cnt[4:3].
- W=2 branch taken misaligned: INIT done -> TRAP 16 cycles, o_ctrl_jump=1 then cleared in IDLE.
- ECALL (ebreak=0): IDLE -> TRAP, mcause=5'b01011; EBREAK gives 5'b00011.
- SERV_IRQ_EN: irq pulse during RUN -> next IDLE+rf_ready enters TRAP, mcause=5'b10111; stall 3 cycles at o_cnt=28 (W=4) delays done 3 cycles.

Source files
------------

// File: rtl/serv_pkg.sv
// serv_pkg: state encoding, mcause codes and datapath-width check shared by the SERV sequencer.
package serv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_TRAP = 2'd3
    } state_t;

    // Exception codes placed in mcause[3:0]
    localparam logic [3:0] MCAUSE_EBREAK         = 4'd3;
    localparam logic [3:0] MCAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] MCAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] MCAUSE_ECALL          = 4'd11;
    localparam logic [3:0] MCAUSE_IRQ_TIMER      = 4'd7;

    function automatic bit w_is_legal(input int w);
        return (w == 1) || (w == 2) || (w == 4) || (w == 8);
    endfunction

endpackage

// File: rtl/serv_seq_cnt.sv
// serv_seq_cnt: chunk counter stepping W bit positions per active, non-stalled cycle.
module serv_seq_cnt
    import serv_pkg::*;
#(
    parameter int W = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_active,
    input  logic       i_stall,
    output logic       o_cnt_en,
    output logic [4:0] o_cnt,
    output logic       o_cnt_done
);

    localparam logic [4:0] STEP = 5'(W);
    localparam logic [4:0] LAST = 5'(32 - W);

    assign o_cnt_en   = i_active & ~i_stall;
    assign o_cnt_done = o_cnt_en & (o_cnt == LAST);

    // The 5-bit sum wraps from 32-W back to 0 by itself.
    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (i_rst)
            o_cnt <= 5'd0;
        else if (o_cnt_en)
            o_cnt <= o_cnt + STEP;
    end

endmodule

// File: rtl/serv_seq_ctrl.sv
// serv_seq_ctrl: per-instruction phase sequencer (IDLE/INIT/RUN/TRAP) for a W-bit serial datapath.
// Define SERV_IRQ_EN to add the pending-interrupt register and interrupt mcause.
module serv_seq_ctrl
    import serv_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_new_irq,
    input  logic         i_rf_ready,
    input  logic         i_stall,
    input  logic         i_take_branch,
    input  logic         i_branch_op,
    input  logic         i_mem_op,
    input  logic         i_shift_op,
    input  logic         i_slt_op,
    input  logic         i_mem_cmd,
    input  logic         i_e_op,
    input  logic         i_ebreak,
    input  logic [4:0]   i_rs1_addr,
    input  logic         i_ctrl_misalign,
    input  logic         i_mem_misalign,
    input  logic         i_alu_sh_done,
    output logic         o_init,
    output logic         o_run,
    output logic         o_ctrl_trap,
    output logic         o_cnt_en,
    output logic [4:0]   o_cnt,
    output logic         o_cnt_done,
    output logic         o_ctrl_pc_en,
    output logic         o_ctrl_jump,
    output logic         o_rf_rs_en,
    output logic         o_alu_shamt_en,
    output logic         o_dbus_cyc,
    output logic         o_bufreg_hold,
    output logic [1:0]   o_mem_bytecnt,
    output logic [W-1:0] o_csr_imm,
    output logic [4:0]   o_csr_mcause
);

    generate
        if (!w_is_legal(W)) begin : g_bad_w
            $error("serv_seq_ctrl: W must be 1, 2, 4 or 8");
        end
    endgenerate

    state_t     state;
    logic       stage_two_pending;
    logic       pending_irq;
    logic       two_stage;
    logic       mem_misalign;
    logic [4:0] mcause_d;

    assign two_stage    = i_slt_op | i_mem_op | i_branch_op | i_shift_op;
    assign mem_misalign = i_mem_op & i_mem_misalign;

    serv_seq_cnt #(.W(W)) u_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_active   (state != ST_IDLE),
        .i_stall    (i_stall),
        .o_cnt_en   (o_cnt_en),
        .o_cnt      (o_cnt),
        .o_cnt_done (o_cnt_done)
    );

`ifdef SERV_IRQ_EN
    // A new request in the same cycle as the trap exit must not be lost.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            pending_irq <= 1'b0;
        else if (i_new_irq)
            pending_irq <= 1'b1;
        else if (state == ST_TRAP && o_cnt_done)
            pending_irq <= 1'b0;
    end
`else
    logic unused_irq;
    assign unused_irq  = i_new_irq;
    assign pending_irq = 1'b0;
`endif

    always_comb begin
        // NOTE: default assignment first so no path leaves mcause_d unassigned (no latch).
        mcause_d = 5'd0;
        if (i_e_op)
            mcause_d = {1'b0, i_ebreak ? MCAUSE_EBREAK : MCAUSE_ECALL};
        else if (mem_misalign)
            mcause_d = {1'b0, i_mem_cmd ? MCAUSE_STORE_MISALIGN : MCAUSE_LOAD_MISALIGN};
        else if (pending_irq)
            mcause_d = {1'b1, MCAUSE_IRQ_TIMER};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state             <= ST_IDLE;
            stage_two_pending <= 1'b0;
            o_ctrl_jump       <= 1'b0;
            o_bufreg_hold     <= 1'b0;
            o_csr_mcause      <= 5'd0;
        end else begin
            o_bufreg_hold <= i_shift_op & o_cnt_done;
            o_csr_mcause  <= mcause_d;
            if (!i_stall) begin
                unique case (state)
                    ST_IDLE: begin
                        o_ctrl_jump <= 1'b0;
                        if (i_rf_ready) begin
                            if (i_e_op || pending_irq)
                                state <= ST_TRAP;
                            else if (two_stage && !stage_two_pending)
                                state <= ST_INIT;
                            else
                                state <= ST_RUN;
                        end else if (i_alu_sh_done && i_shift_op && stage_two_pending) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_INIT: begin
                        o_ctrl_jump <= i_take_branch;
                        if (o_cnt_done) begin
                            stage_two_pending <= 1'b1;
                            if (mem_misalign || (i_take_branch && i_ctrl_misalign))
                                state <= ST_TRAP;
                            else if (i_mem_op || i_shift_op)
                                state <= ST_IDLE;
                            else
                                state <= ST_RUN;
                        end
                    end
                    ST_RUN, ST_TRAP: begin
                        if (o_cnt_done) begin
                            state             <= ST_IDLE;
                            stage_two_pending <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_init         = (state == ST_INIT);
    assign o_run          = (state == ST_RUN);
    assign o_ctrl_trap    = (state == ST_TRAP);
    assign o_ctrl_pc_en   = o_run | o_ctrl_trap;
    assign o_rf_rs_en     = two_stage ? o_init : o_ctrl_pc_en;
    assign o_alu_shamt_en = o_init & (o_cnt < 5'd5);
    assign o_dbus_cyc     = (state == ST_IDLE) & stage_two_pending & i_mem_op & ~mem_misalign;
    assign o_mem_bytecnt  = o_cnt[4:3];

    // Serialised CSR immediate: bits of rs1 beyond index 4 read as zero.
    logic [7:0] rs1_ext;
    assign rs1_ext = {3'b000, i_rs1_addr};

    always_comb begin
        logic [5:0] idx;
        o_csr_imm = '0;
        for (int i = 0; i < W; i++) begin
            idx = {1'b0, o_cnt} + 6'(i);
            if (idx < 6'd5)
                o_csr_imm[i] = rs1_ext[idx[2:0]];
        end
    end

endmodule
